// File: rtl/dram_pkg.sv
// Shared types and default timing for the DRAM emulator.
package dram_pkg;

  localparam int TRAS_MIN_DEF      = 5;
  localparam int TRP_MIN_DEF       = 4;
  localparam int REFRESH_LIMIT_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE,
    ROW_OPEN,
    COL_ACTIVE,
    CBR_WAIT,
    CBR_ACTIVE,
    PRECHARGE
  } state_t;

endpackage

// File: rtl/dram_emu_if.sv
// DRAM pin bundle between a controller (master) and the emulator (slave).
interface dram_emu_if;
  logic [7:0] ram_addr;
  logic       ram_ras_;
  logic       ram_cas_;
  logic       ram_we_;
  logic       ram_oe_;
  logic [3:0] dq_i;
  logic [3:0] dq_o;
  logic       dq_oe;

  modport master (
    output ram_addr, ram_ras_, ram_cas_, ram_we_, ram_oe_, dq_i,
    input  dq_o, dq_oe
  );

  modport slave (
    input  ram_addr, ram_ras_, ram_cas_, ram_we_, ram_oe_, dq_i,
    output dq_o, dq_oe
  );
endinterface

// File: rtl/dram_emu_mem.sv
// 64K x 4 single-port synchronous RAM, read-first, no reset.
module dram_emu_mem (
  input  logic        clk,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [3:0]  wdata,
  output logic [3:0]  rdata
);

  logic [3:0] mem [0:65535];

  // Write on demand, registered read every cycle.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dram_emu.sv
// Asynchronous-DRAM behavioural target: RAS/CAS decode, early write,
// read with output enable, CBR refresh counting and timing checks.
//
// state      | meaning
// IDLE       | RAS and CAS high, nothing open
// ROW_OPEN   | row latched, waiting for CAS fall
// COL_ACTIVE | column access in progress (CAS low)
// CBR_WAIT   | CAS fell first, waiting for RAS fall
// CBR_ACTIVE | refresh in progress, waiting for RAS rise
// PRECHARGE  | RAS high, counting toward TRP_MIN
module dram_emu
  import dram_pkg::*;
#(
  parameter int TRAS_MIN      = TRAS_MIN_DEF,
  parameter int TRP_MIN       = TRP_MIN_DEF,
  parameter int REFRESH_LIMIT = REFRESH_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  dram_emu_if.slave   bus,
  output logic [15:0] cbr_count,
  output logic        refresh_err,
  output logic        proto_err
);

  localparam logic [15:0] TRAS_C  = 16'(TRAS_MIN);
  localparam logic [15:0] TRP_C   = 16'(TRP_MIN);
  localparam logic [15:0] LIMIT_C = 16'(REFRESH_LIMIT);

  logic        s_ras, s_cas, s_we, s_oe, p_ras, p_cas;
  logic [7:0]  s_addr;
  logic [3:0]  s_dq;
  logic        ras_fall, ras_rise, cas_fall, cas_rise, pend_now;
  state_t      state, state_d;
  logic        latch_row, col_issue, cbr_done, pre_viol;
  logic        pend_set, pend_clr, pre_start, pre_inc;
  logic [7:0]  row_q, col_q;
  logic        cyc_read, cbr_pend, rd_pend, rd_valid;
  logic [3:0]  dq_hold, mem_rdata;
  logic [15:0] ras_cnt, pre_cnt, rfsh_tmr, mem_addr;
  logic        mem_we;

  // Input capture; the previous strobe copy starts high so no edge is seen on the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ras <= 1'b1; s_cas <= 1'b1; s_we <= 1'b1; s_oe <= 1'b1;
      p_ras <= 1'b1; p_cas <= 1'b1;
      s_addr <= '0; s_dq <= '0;
    end else begin
      s_ras <= bus.ram_ras_; s_cas <= bus.ram_cas_;
      s_we  <= bus.ram_we_;  s_oe  <= bus.ram_oe_;
      p_ras <= s_ras; p_cas <= s_cas;
      s_addr <= bus.ram_addr; s_dq <= bus.dq_i;
    end
  end

  assign ras_fall = p_ras & ~s_ras;
  assign ras_rise = ~p_ras & s_ras;
  assign cas_fall = p_cas & ~s_cas;
  assign cas_rise = ~p_cas & s_cas;
  // A CBR requested during precharge is still live only while CAS stays low.
  assign pend_now = cas_fall | (cbr_pend & ~s_cas);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state decode and per-cycle action strobes.
  always_comb begin
    state_d   = state;
    latch_row = 1'b0;
    col_issue = 1'b0;
    cbr_done  = 1'b0;
    pre_viol  = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    pre_start = 1'b0;
    pre_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (ras_fall && s_cas) begin
          latch_row = 1'b1;
          state_d   = ROW_OPEN;
        end else if (cas_fall && s_ras) begin
          state_d = CBR_WAIT;
        end
      end
      ROW_OPEN: begin
        if (ras_rise) begin
          pre_start = 1'b1;
          state_d   = PRECHARGE;
        end else if (cas_fall) begin
          col_issue = 1'b1;
          state_d   = COL_ACTIVE;
        end
      end
      COL_ACTIVE: begin
        if (ras_rise) begin
          pre_start = 1'b1;
          state_d   = PRECHARGE;
        end else if (cas_rise) begin
          state_d = ROW_OPEN;
        end
      end
      CBR_WAIT: begin
        if (ras_fall)      state_d = CBR_ACTIVE;
        else if (cas_rise) state_d = IDLE;
      end
      CBR_ACTIVE: begin
        if (ras_rise) begin
          cbr_done  = 1'b1;
          pre_start = 1'b1;
          state_d   = PRECHARGE;
        end
      end
      PRECHARGE: begin
        if (cas_fall)      pend_set = 1'b1;
        else if (cas_rise) pend_clr = 1'b1;
        if (ras_fall) begin
          // Early re-open: flag it, then treat the fall as IDLE would.
          pre_viol = (pre_cnt < TRP_C);
          pend_clr = 1'b1;
          if (s_cas) begin
            latch_row = 1'b1;
            state_d   = ROW_OPEN;
          end else if (pend_now) begin
            state_d = CBR_ACTIVE;
          end else begin
            state_d = IDLE;
          end
        end else if (pre_cnt + 16'd1 >= TRP_C) begin
          // pre_cnt holds earlier high cycles; +1 counts the current one.
          pend_clr = 1'b1;
          state_d  = pend_now ? CBR_WAIT : IDLE;
        end else begin
          pre_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row/column latches, read pipeline and pending-CBR flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0; col_q <= '0; cyc_read <= 1'b0;
      rd_pend <= 1'b0; rd_valid <= 1'b0; dq_hold <= '0; cbr_pend <= 1'b0;
    end else begin
      if (latch_row) row_q <= s_addr;
      if (col_issue) begin
        col_q    <= s_addr;
        cyc_read <= s_we;
      end
      rd_pend <= col_issue & s_we;
      if (col_issue)    rd_valid <= 1'b0;
      else if (rd_pend) rd_valid <= 1'b1;
      if (rd_pend) dq_hold <= mem_rdata;
      if (pend_clr)      cbr_pend <= 1'b0;
      else if (pend_set) cbr_pend <= 1'b1;
    end
  end

  // Timing counters, refresh count and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_cnt <= '0; pre_cnt <= '0; rfsh_tmr <= '0; cbr_count <= '0;
      refresh_err <= 1'b0; proto_err <= 1'b0;
    end else begin
      if (s_ras)                     ras_cnt <= '0;
      else if (ras_cnt != 16'hffff)  ras_cnt <= ras_cnt + 16'd1;
      if (pre_start)    pre_cnt <= 16'd1;
      else if (pre_inc) pre_cnt <= pre_cnt + 16'd1;
      if (cbr_done)                   rfsh_tmr <= '0;
      else if (rfsh_tmr != 16'hffff)  rfsh_tmr <= rfsh_tmr + 16'd1;
      if (cbr_done) cbr_count <= cbr_count + 16'd1;
      if (rfsh_tmr >= LIMIT_C) refresh_err <= 1'b1;
      if ((ras_rise && ras_cnt < TRAS_C) || pre_viol || (cas_fall && !s_we && !s_oe))
        proto_err <= 1'b1;
    end
  end

  // Column address comes straight from s_addr on the issue cycle so the access is not delayed.
  assign mem_addr = col_issue ? {row_q, s_addr} : {row_q, col_q};
  assign mem_we   = col_issue & ~s_we;

  dram_emu_mem u_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (s_dq),
    .rdata (mem_rdata)
  );

  assign bus.dq_o  = rd_pend ? mem_rdata : dq_hold;
  assign bus.dq_oe = (state == COL_ACTIVE) & cyc_read & (rd_pend | rd_valid) &
                     ~s_oe & ~s_cas & ~s_ras;

endmodule

// File: tb/tb_dram_emu.sv
// Directed plus randomized bench for dram_emu with a behavioural memory model.
module tb_dram_emu;
  import dram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cbr_count;
  logic        refresh_err, proto_err;

  dram_emu_if bus ();

  dram_emu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cbr_count   (cbr_count),
    .refresh_err (refresh_err),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0]  mdl_mem [logic [15:0]];
  logic [15:0] wr_q [$];
  int          mdl_cbr;
  logic        mdl_proto;
  logic [3:0]  last_rd;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pins_idle();
    bus.ram_addr = '0; bus.ram_ras_ = 1'b1; bus.ram_cas_ = 1'b1;
    bus.ram_we_  = 1'b1; bus.ram_oe_ = 1'b1; bus.dq_i = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dq_o"},  bus.dq_o, 16'h0);
    check({tag, "_dq_oe"}, bus.dq_oe, 16'h0);
    check({tag, "_cbr"},   cbr_count, 16'h0);
    check({tag, "_rerr"},  refresh_err, 16'h0);
    check({tag, "_perr"},  proto_err, 16'h0);
    check({tag, "_state"}, 16'(dut.state), 16'(IDLE));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    pins_idle();
    repeat (3) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    mdl_cbr = 0; mdl_proto = 1'b0; last_rd = 4'h0;
    tick();
  endtask

  // One RAS/CAS access: RAS low l_ras cycles, RAS high t_pre cycles afterwards.
  task automatic access(input logic [15:0] a, input bit wr, input logic [3:0] d,
                        input bit oe_low, input int l_ras, input int t_pre,
                        output logic [3:0] rd, output logic oe_seen);
    bus.ram_addr = a[15:8]; bus.ram_ras_ = 1'b0;
    tick();
    bus.ram_addr = a[7:0]; bus.ram_we_ = ~wr; bus.ram_oe_ = ~oe_low; bus.dq_i = d;
    tick();
    bus.ram_cas_ = 1'b0;
    tick(); tick();
    rd = bus.dq_o; oe_seen = bus.dq_oe;
    repeat (l_ras - 5) tick();
    bus.ram_cas_ = 1'b1; bus.ram_we_ = 1'b1; bus.ram_oe_ = 1'b1;
    tick();
    bus.ram_ras_ = 1'b1;
    repeat (t_pre) tick();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [3:0] d, input bit oe_low,
                          input int l_ras, input int t_pre);
    logic [3:0] rd;
    logic       oe_seen;
    access(a, 1'b1, d, oe_low, l_ras, t_pre, rd, oe_seen);
    mdl_mem[a] = d;
    wr_q.push_back(a);
    if (oe_low) mdl_proto = 1'b1;
    check("wr_dq_oe", oe_seen, 16'h0);
    check("wr_hold", bus.dq_o, last_rd);
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input bit oe_low,
                         input int l_ras, input int t_pre);
    logic [3:0] rd;
    logic       oe_seen;
    access(a, 1'b0, 4'h0, oe_low, l_ras, t_pre, rd, oe_seen);
    last_rd = mdl_mem[a];
    check({tag, "_dq"}, rd, last_rd);
    check({tag, "_oe"}, oe_seen, 16'(oe_low));
    check({tag, "_hold"}, bus.dq_o, last_rd);
  endtask

  task automatic do_cbr(input int t_pre);
    logic oe_any;
    oe_any = 1'b0;
    bus.ram_cas_ = 1'b0; bus.ram_oe_ = 1'b0;
    repeat (5) begin tick(); oe_any |= bus.dq_oe; end
    bus.ram_ras_ = 1'b0;
    repeat (5) begin tick(); oe_any |= bus.dq_oe; end
    bus.ram_ras_ = 1'b1; bus.ram_cas_ = 1'b1; bus.ram_oe_ = 1'b1;
    repeat (t_pre) tick();
    mdl_cbr++;
    check("cbr_oe", oe_any, 16'h0);
    check("cbr_count", cbr_count, 16'(mdl_cbr));
  endtask

  initial begin
    logic [15:0] a;
    int          op;
    pins_idle();
    reset_dut();

    // Basic write then read, and address extremes at minimum legal timing.
    do_write(16'h1234, 4'hA, 1'b0, 6, 5);
    do_read("rd1234", 16'h1234, 1'b1, 6, 5);
    check("perr_basic", proto_err, 16'h0);
    do_write(16'hffff, 4'h5, 1'b0, 5, 4);
    do_write(16'h0000, 4'h3, 1'b0, 5, 4);
    do_read("rdffff", 16'hffff, 1'b1, 5, 4);
    do_read("rd0000", 16'h0000, 1'b1, 5, 4);
    check("perr_min_timing", proto_err, 16'h0);

    // Random mix of writes, reads and refreshes.
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 9));
      if (op < 2) begin
        do_cbr(int'($urandom_range(4, 6)));
      end else if (op < 6 || wr_q.size() == 0) begin
        if (wr_q.size() != 0 && $urandom_range(0, 1) == 0)
          a = wr_q[$urandom_range(0, wr_q.size() - 1)];
        else
          a = 16'($urandom_range(0, 65535));
        do_write(a, 4'($urandom_range(0, 15)), 1'b0,
                 int'($urandom_range(5, 8)), int'($urandom_range(4, 6)));
      end else begin
        a = wr_q[$urandom_range(0, wr_q.size() - 1)];
        do_read("rnd_rd", a, bit'($urandom_range(0, 1)),
                int'($urandom_range(5, 8)), int'($urandom_range(4, 6)));
      end
    end
    check("rnd_perr", proto_err, 16'(mdl_proto));
    check("rnd_cbr", cbr_count, 16'(mdl_cbr));

    // WE and OE both low at CAS fall: error, but still a write.
    do_write(16'h4242, 4'hC, 1'b1, 6, 5);
    do_read("rd_weoe", 16'h4242, 1'b1, 6, 5);
    check("perr_weoe", proto_err, 16'(mdl_proto));

    // Eight refreshes leave memory untouched.
    reset_dut();
    for (int i = 0; i < 8; i++) do_cbr(5);
    check("cbr8", cbr_count, 16'd8);
    do_read("rd_after_cbr", 16'h1234, 1'b1, 6, 5);

    // Refresh interval violation is sticky.
    reset_dut();
    repeat (995) tick();
    check("rerr_before", refresh_err, 16'h0);
    repeat (10) tick();
    check("rerr_after", refresh_err, 16'h1);
    do_cbr(5);
    check("rerr_sticky", refresh_err, 16'h1);

    // RAS low too short.
    reset_dut();
    bus.ram_addr = 8'h01; bus.ram_ras_ = 1'b0;
    repeat (3) tick();
    bus.ram_ras_ = 1'b1;
    repeat (6) tick();
    check("perr_tras", proto_err, 16'h1);

    // RAS re-falls two cycles after rising.
    reset_dut();
    bus.ram_addr = 8'h02; bus.ram_ras_ = 1'b0;
    repeat (6) tick();
    bus.ram_ras_ = 1'b1;
    repeat (2) tick();
    check("perr_trp_pre", proto_err, 16'h0);
    bus.ram_ras_ = 1'b0;
    repeat (6) tick();
    bus.ram_ras_ = 1'b1;
    repeat (6) tick();
    check("perr_trp", proto_err, 16'h1);

    // Reset during a write's CAS-low period aborts the write.
    reset_dut();
    do_write(16'hBEEF, 4'h6, 1'b0, 6, 5);
    bus.ram_addr = 8'hBE; bus.ram_ras_ = 1'b0;
    tick();
    bus.ram_addr = 8'hEF; bus.ram_we_ = 1'b0; bus.dq_i = 4'h9;
    tick();
    bus.ram_cas_ = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    pins_idle();
    repeat (2) tick();
    rst_n = 1'b1;
    mdl_cbr = 0; mdl_proto = 1'b0; last_rd = 4'h0;
    repeat (2) tick();
    do_read("rd_after_rst", 16'hBEEF, 1'b1, 6, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
